iq_upconverter_sd: RTL and testbench
====================================

# iq_upconverter_sd

Transmit-side counterpart of the receive mixer. The block accepts baseband I/Q samples over a valid/ready handshake and holds each sample for a fixed number of clocks. It mixes the held sample with the NCO cosine/sine (I·cos − Q·sin) and drives the 12-bit result through a first-order sigma-delta modulator, producing a 1-bit RF stream. It sits between the baseband source and the single-ended/LVDS output pin, fed by the same NCO as the receive path.

## Interface
- DATA_WIDTH, 12, width of I/Q, NCO and mixed samples (signed).
- INTERP, 64, clocks per baseband sample (≥4).
- clk  in  1  system clock.
- arst  in  1  reset, asynchronous, active-high.
- i_in  in  DATA_WIDTH  baseband I, signed.
- q_in  in  DATA_WIDTH  baseband Q, signed.
- iq_valid  in  1  I/Q offered.
- iq_ready  out  1  next-sample buffer empty.
- sinewave_in  in  DATA_WIDTH  NCO sine, signed.
- cosinewave_in  in  DATA_WIDTH  NCO cosine, signed.
- rf_out  out  1  sigma-delta RF bitstream.
- underrun  out  1  one-cycle pulse: load point reached with no sample available.

## Operation
- Two sample registers: next (with next_full flag) and current. iq_ready = ~next_full. A handshake occurs when iq_valid & iq_ready, and writes next and sets next_full.
- Phase counter 0..INTERP-1 wraps. load = (count == INTERP-1).
- On load with next_full=1, current ← next and next_full ← 0.
- On load with next_full=0 and a handshake in the same cycle, the incoming sample bypasses straight into current and next_full stays 0. This is not an underrun.
- On load with next_full=0 and no handshake, an underrun occurs: underrun pulses 1 and current follows the Configuration rule.
- A handshake with no load fills next. A handshake is impossible while next_full=1.
- Stage 1: p_i = current_i·cos, p_q = current_q·sin. Each product is 2·DATA_WIDTH signed bits, registered.
- Stage 2: s = p_i − p_q (2·DATA_WIDTH+1 bits). mix = s arithmetically shifted right by DATA_WIDTH−1, then saturated to DATA_WIDTH signed bits (±2047 for 12 bits). mix is registered.
- Stage 3 is the sigma-delta modulator.
  - Accumulator is DATA_WIDTH+2 bits signed.
  - fb = +(2^(DATA_WIDTH−1)−1) when rf_out=1, else −2^(DATA_WIDTH−1).
  - acc ← acc + mix − fb.
  - rf_out ← (acc_next ≥ 0), registered.

## Timing
- Reset values:
  - iq_ready=1, next_full=0, current=0, count=0, underrun=0.
  - p_i/p_q=0, mix=0, acc=0, rf_out=0.
- Latency:
  - NCO/current at cycle n → products at n+1 → mix at n+2 → rf_out at n+3.
  - A sample accepted in cycle t affects rf_out no earlier than the load following t, +3.
- The first load after reset occurs INTERP−1 cycles after arst deasserts.
- iq_ready deasserts the cycle after a handshake and reasserts the cycle after the load that empties next.
- Reset mid-operation clears everything immediately, including the partially filled buffer and the accumulator. There is no output glitch beyond rf_out going to 0.
- The accumulator cannot overflow: |mix| ≤ 2047 and the feedback bounds acc within ±4095 at 12 bits.

## Configuration
- UPCONV_UNDERRUN_ZERO_EN defined: on underrun, current is cleared to I=Q=0, so the carrier is muted until the next sample.
- UPCONV_UNDERRUN_ZERO_EN undefined: on underrun, current holds its previous value, so the last sample repeats.
- The underrun pulse is identical in both builds.

## Structure
- Shared package sdr_pkg holds:
  - DATA_WIDTH constant.
  - iq_sample_t packed struct {i, q}.
  - Sigma-delta feedback constants SD_FB_POS/SD_FB_NEG.
  - Saturation helper function.
- Sub-module sigma_delta_mod1 contains stage 3 (mix in, rf_out out, own acc, clk/arst). The top level holds the buffer, the counter, and stages 1–2.

## Test plan
- Reset, then hold I=Q=0, cos=2047, sin=0 → mix=0; rf_out toggles 0/1 alternating with ~50% density; iq_ready=1.
- Offer I=1024, Q=0 with cos constant 2047 → after load+2, mix=1023; rf_out density ≈ 75% ones over 256 cycles.
- Offer I=2047, Q=−2048, cos=2047, sin=2047 → s exceeds range; mix saturates to 2047. No accumulator wrap; rf_out is all ones except the occasional 0.
- Stop iq_valid → at the load, underrun pulses exactly 1 cycle. With the macro, mix→0; without it, mix is unchanged.
- Assert iq_valid on the exact load cycle with next empty → sample loaded into current that cycle, underrun=0, iq_ready stays 1.
- Assert arst mid-sample with next_full=1 → next cleared, iq_ready=1, rf_out=0, count restarts at 0.

Source files
------------

// File: rtl/sdr_pkg.sv
// sdr_pkg: shared SDR datapath types, sigma-delta feedback levels and mix saturation.
// Rev 1.0
`default_nettype none

package sdr_pkg;

   localparam int DATA_WIDTH = 12;
   localparam int ACC_WIDTH  = DATA_WIDTH + 2;
   localparam int PROD_WIDTH = 2 * DATA_WIDTH;
   localparam int SUM_WIDTH  = 2 * DATA_WIDTH + 1;

   typedef struct packed {
      logic signed [DATA_WIDTH-1:0] i;
      logic signed [DATA_WIDTH-1:0] q;
   } iq_sample_t;

   localparam logic signed [ACC_WIDTH-1:0] SD_FB_POS = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SD_FB_NEG = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

   // Rescale the mixer sum back to sample range; clamp symmetrically so |mix| never exceeds full scale.
   function automatic logic signed [DATA_WIDTH-1:0] sat_mix(input logic signed [SUM_WIDTH-1:0] s);
      logic signed [SUM_WIDTH-1:0] sh;
      logic signed [SUM_WIDTH-1:0] hi;
      logic signed [SUM_WIDTH-1:0] lo;
      hi = SUM_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
      lo = -hi;
      sh = s >>> (DATA_WIDTH - 1);
      if (sh > hi)
         sat_mix = hi[DATA_WIDTH-1:0];
      else if (sh < lo)
         sat_mix = lo[DATA_WIDTH-1:0];
      else
         sat_mix = sh[DATA_WIDTH-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/sigma_delta_mod1.sv
// sigma_delta_mod1: first-order 1-bit sigma-delta modulator for the upconverter output.
// Rev 1.0
`default_nettype none

module sigma_delta_mod1
   import sdr_pkg::*;
(
   input  logic                         clk,
   input  logic                         arst,
   input  logic signed [DATA_WIDTH-1:0] mix_i,
   output logic                         rf_out_o
);

   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] acc_d;
   logic signed [ACC_WIDTH-1:0] fb;

   // Two guard bits: with |mix| <= full scale the loop keeps acc within about +/-2*full scale.
   always_comb begin
      fb    = rf_out_o ? SD_FB_POS : SD_FB_NEG;
      acc_d = acc_q + ACC_WIDTH'(mix_i) - fb;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         acc_q    <= '0;
         rf_out_o <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         rf_out_o <= ~acc_d[ACC_WIDTH-1];
      end
   end

endmodule

`default_nettype wire

// File: rtl/iq_upconverter_sd.sv
// iq_upconverter_sd: I/Q hold-interpolator, NCO mixer and sigma-delta RF bitstream output.
// Option macro UPCONV_UNDERRUN_ZERO_EN: mute (zero) the held sample on underrun. Rev 1.0
`default_nettype none

module iq_upconverter_sd
   import sdr_pkg::*;
#(
   parameter int INTERP = 64
) (
   input  logic                         clk,
   input  logic                         arst,
   input  logic signed [DATA_WIDTH-1:0] i_in,
   input  logic signed [DATA_WIDTH-1:0] q_in,
   input  logic                         iq_valid,
   output logic                         iq_ready,
   input  logic signed [DATA_WIDTH-1:0] sinewave_in,
   input  logic signed [DATA_WIDTH-1:0] cosinewave_in,
   output logic                         rf_out,
   output logic                         underrun
);

   localparam int CNT_W = $clog2(INTERP);

   logic [CNT_W-1:0]            count_q;
   iq_sample_t                  next_q, next_d;
   iq_sample_t                  cur_q, cur_d;
   iq_sample_t                  in_s;
   logic                        next_full_q, next_full_d;
   logic                        underrun_q, underrun_d;
   logic                        hs;
   logic                        load;
   logic signed [PROD_WIDTH-1:0] p_i_q, p_q_q;
   logic signed [SUM_WIDTH-1:0]  sum;
   logic signed [DATA_WIDTH-1:0] mix_q;

   assign in_s     = {i_in, q_in};
   assign load     = (count_q == CNT_W'(INTERP - 1));
   assign hs       = iq_valid & ~next_full_q;
   assign iq_ready = ~next_full_q;
   assign underrun = underrun_q;

   always_comb begin
      next_d      = next_q;
      next_full_d = next_full_q;
      cur_d       = cur_q;
      underrun_d  = 1'b0;
      if (load) begin
         if (next_full_q) begin
            cur_d       = next_q;
            next_full_d = 1'b0;
         end else if (hs) begin
            // Sample arriving exactly at the load point skips the next buffer.
            cur_d = in_s;
         end else begin
            underrun_d = 1'b1;
`ifdef UPCONV_UNDERRUN_ZERO_EN
            cur_d = '0;
`else
            cur_d = cur_q;
`endif
         end
      end else if (hs) begin
         next_d      = in_s;
         next_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         count_q     <= '0;
         next_q      <= '0;
         next_full_q <= 1'b0;
         cur_q       <= '0;
         underrun_q  <= 1'b0;
      end else begin
         count_q     <= load ? '0 : count_q + CNT_W'(1);
         next_q      <= next_d;
         next_full_q <= next_full_d;
         cur_q       <= cur_d;
         underrun_q  <= underrun_d;
      end
   end

   assign sum = SUM_WIDTH'(p_i_q) - SUM_WIDTH'(p_q_q);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         p_i_q <= '0;
         p_q_q <= '0;
         mix_q <= '0;
      end else begin
         p_i_q <= PROD_WIDTH'(cur_q.i) * PROD_WIDTH'(cosinewave_in);
         p_q_q <= PROD_WIDTH'(cur_q.q) * PROD_WIDTH'(sinewave_in);
         mix_q <= sat_mix(sum);
      end
   end

   sigma_delta_mod1 u_sdm (
      .clk      (clk),
      .arst     (arst),
      .mix_i    (mix_q),
      .rf_out_o (rf_out)
   );

endmodule

`default_nettype wire

// File: tb/tb_iq_upconverter_sd.sv
// tb_iq_upconverter_sd: directed scenarios plus random traffic against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_iq_upconverter_sd;
   import sdr_pkg::*;

   localparam int INTERP = 64;

   logic                         clk = 1'b0;
   logic                         arst = 1'b1;
   logic signed [DATA_WIDTH-1:0] i_in = '0;
   logic signed [DATA_WIDTH-1:0] q_in = '0;
   logic signed [DATA_WIDTH-1:0] sinewave_in = '0;
   logic signed [DATA_WIDTH-1:0] cosinewave_in = '0;
   logic                         iq_valid = 1'b0;
   logic                         iq_ready;
   logic                         rf_out;
   logic                         underrun;

   always #5 clk = ~clk;

   iq_upconverter_sd #(.INTERP(INTERP)) dut (
      .clk           (clk),
      .arst          (arst),
      .i_in          (i_in),
      .q_in          (q_in),
      .iq_valid      (iq_valid),
      .iq_ready      (iq_ready),
      .sinewave_in   (sinewave_in),
      .cosinewave_in (cosinewave_in),
      .rf_out        (rf_out),
      .underrun      (underrun)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // floor(s / 2^(W-1)) clamped to +/- full scale
   function automatic int sat_ref(input int s);
      int d;
      d = s / 2048;
      if (s < 0 && (s % 2048) != 0) d = d - 1;
      if (d > 2047) d = 2047;
      if (d < -2047) d = -2047;
      return d;
   endfunction

   // Behavioural model: sample buffer as a queue of depth <= 1, datapath as integer arithmetic.
   int m_cnt, m_cur_i, m_cur_q, m_pi, m_pq, m_mix, m_acc, m_rf, m_under;
   int m_nxt_i[$];
   int m_nxt_q[$];

   always @(posedge clk) begin
      bit hs, ld, has;
      int a;
      if (arst) begin
         m_cnt <= 0; m_cur_i <= 0; m_cur_q <= 0; m_pi <= 0; m_pq <= 0;
         m_mix <= 0; m_acc <= 0; m_rf <= 0; m_under <= 0;
         m_nxt_i.delete();
         m_nxt_q.delete();
      end else begin
         has = (m_nxt_i.size() != 0);
         hs  = iq_valid && !has;
         ld  = (m_cnt == INTERP - 1);
         a   = m_acc + m_mix - (m_rf != 0 ? 2047 : -2048);
         m_acc   <= a;
         m_rf    <= (a >= 0) ? 1 : 0;
         m_mix   <= sat_ref(m_pi - m_pq);
         m_pi    <= m_cur_i * int'(cosinewave_in);
         m_pq    <= m_cur_q * int'(sinewave_in);
         m_cnt   <= ld ? 0 : m_cnt + 1;
         m_under <= (ld && !has && !hs) ? 1 : 0;
         if (ld && has) begin
            m_cur_i <= m_nxt_i.pop_front();
            m_cur_q <= m_nxt_q.pop_front();
         end else if (ld && hs) begin
            m_cur_i <= int'(i_in);
            m_cur_q <= int'(q_in);
         end else if (ld) begin
`ifdef UPCONV_UNDERRUN_ZERO_EN
            m_cur_i <= 0;
            m_cur_q <= 0;
`endif
         end else if (hs) begin
            m_nxt_i.push_back(int'(i_in));
            m_nxt_q.push_back(int'(q_in));
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("iq_ready", iq_ready, (m_nxt_i.size() == 0) ? 1 : 0);
         check_eq("underrun", underrun, m_under);
         check_eq("rf_out", rf_out, m_rf);
         check_eq("mix", $signed(dut.mix_q), m_mix);
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_in(input int i, input int q, input int c, input int s, input bit v);
      i_in          = DATA_WIDTH'(i);
      q_in          = DATA_WIDTH'(q);
      cosinewave_in = DATA_WIDTH'(c);
      sinewave_in   = DATA_WIDTH'(s);
      iq_valid      = v;
   endtask

   task automatic count_ones(input int n, output int ones);
      ones = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         ones += int'(rf_out);
      end
   endtask

   task automatic wait_count(input int target, input string tag);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 2 * INTERP && !found; k++) begin
         if (m_cnt == target) found = 1'b1;
         else tick();
      end
      check_eq(tag, found, 1);
   endtask

   initial begin
      int ones, pulses, run, maxrun, k_seen;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_ready", iq_ready, 1);
      check_eq("rst_rf", rf_out, 0);
      check_eq("rst_underrun", underrun, 0);
      check_eq("rst_mix", $signed(dut.mix_q), 0);
      arst   = 1'b0;
      chk_en = 1'b1;

      // Zero baseband: mix 0, ~50% density
      set_in(0, 0, 2047, 0, 1'b1);
      repeat (2 * INTERP) tick();
      check_eq("p1_mix", $signed(dut.mix_q), 0);
      count_ones(256, ones);
      check_eq("p1_ones~128", (ones >= 126 && ones <= 130) ? 128 : ones, 128);

      // Half-scale I: mix 1023, ~75% density
      set_in(1024, 0, 2047, 0, 1'b1);
      repeat (3 * INTERP) tick();
      check_eq("p2_mix", $signed(dut.mix_q), 1023);
      count_ones(256, ones);
      check_eq("p2_ones~192", (ones >= 189 && ones <= 195) ? 192 : ones, 192);

      // Saturating case
      set_in(2047, -2048, 2047, 2047, 1'b1);
      repeat (3 * INTERP) tick();
      check_eq("p3_mix_sat", $signed(dut.mix_q), 2047);
      count_ones(256, ones);
      check_eq("p3_ones>=254", (ones >= 254) ? 256 : ones, 256);

      // Source stops: underrun pulses are single cycles
      iq_valid = 1'b0;
      pulses = 0; run = 0; maxrun = 0;
      for (int k = 0; k < 3 * INTERP; k++) begin
         tick();
         if (underrun) begin
            run++;
            if (run == 1) pulses++;
            if (run > maxrun) maxrun = run;
         end else begin
            run = 0;
         end
      end
      check_eq("p4_underrun_seen", (pulses >= 1) ? 1 : 0, 1);
      check_eq("p4_pulse_width", maxrun, 1);
`ifdef UPCONV_UNDERRUN_ZERO_EN
      check_eq("p4_mix_after_underrun", $signed(dut.mix_q), 0);
`else
      check_eq("p4_mix_after_underrun", $signed(dut.mix_q), 2047);
`endif

      // Sample offered exactly on the load cycle with next empty
      set_in(0, 0, 2047, 0, 1'b0);
      wait_count(INTERP - 1, "p5_align");
      set_in(500, -300, 2047, 0, 1'b1);
      @(negedge clk);
      #1;
      check_eq("p5_bypass_underrun", underrun, 0);
      check_eq("p5_bypass_ready", iq_ready, 1);
      iq_valid = 1'b0;
      tick();
      tick();
      check_eq("p5_bypass_mix", $signed(dut.mix_q), 499);

      // Reset with next buffer full
      wait_count(10, "p6_align");
      set_in(100, 50, 2047, 0, 1'b1);
      tick();
      check_eq("p6_next_full", iq_ready, 0);
      iq_valid = 1'b0;
      tick();
      chk_en = 1'b0;
      arst   = 1'b1;
      #1;
      check_eq("p6_rst_ready", iq_ready, 1);
      check_eq("p6_rst_rf", rf_out, 0);
      check_eq("p6_rst_underrun", underrun, 0);
      tick();
      arst   = 1'b0;
      chk_en = 1'b1;
      k_seen = 0;
      for (int k = 1; k <= 2 * INTERP && k_seen == 0; k++) begin
         @(negedge clk);
         if (underrun) k_seen = k;
      end
      check_eq("p6_first_load", k_seen, INTERP);
      #1;

      // Random traffic
      for (int k = 0; k < 1500; k++) begin
         tick();
         i_in          = DATA_WIDTH'($urandom);
         q_in          = DATA_WIDTH'($urandom);
         cosinewave_in = DATA_WIDTH'($urandom);
         sinewave_in   = DATA_WIDTH'($urandom);
         iq_valid      = ($urandom_range(0, 3) == 0);
      end
      tick();
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
